mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (CPU = 0, NI = 1) in front of a single-port memory with 1-cycle read latency.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the CPU wins every tie.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [1:0]                           req_valid,
    output logic [1:0]                           req_ready,
    input  logic [1:0]                           req_lock,
    input  logic [1:0][ADDR_WIDTH-1:0]           req_addr,
    input  logic [1:0][DATA_WIDTH/8-1:0]         req_wb,
    input  logic [1:0][DATA_WIDTH-1:0]           req_data,
    output logic [1:0]                           rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_data,
    output logic                                 mem_enable,
    output logic [DATA_WIDTH/8-1:0]              mem_wb,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    input  logic [DATA_WIDTH-1:0]                mem_rdata
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_OPEN    = 2'b00,
        ST_LOCKED0 = 2'b01,
        ST_LOCKED1 = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  w_grant;
    logic [1:0]  w_fire;
    logic        w_sel;
    logic [1:0]  w_is_read;
    logic [1:0]  r_rsp_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        r_ptr;
`endif

    // Grant selection: a lock pins the grant to its owner even when the owner is idle.
    always_comb begin
        w_grant = 2'b00;
        case (r_state)
            ST_OPEN: begin
                if (req_valid == 2'b11) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (r_ptr) begin
                        w_grant = 2'b10;
                    end else begin
                        w_grant = 2'b01;
                    end
`else
                    w_grant = 2'b01;
`endif
                end else begin
                    w_grant = req_valid;
                end
            end
            ST_LOCKED0: w_grant = {1'b0, req_valid[0]};
            ST_LOCKED1: w_grant = {req_valid[1], 1'b0};
            default:    w_grant = 2'b00;
        endcase
    end

    // Ready is masked while reset is held so nothing can transfer during reset.
    always_comb begin
        req_ready = 2'b00;
        if (reset) begin
            req_ready = w_grant;
        end else begin
            req_ready = 2'b00;
        end
    end

    assign w_fire    = req_ready & req_valid;
    assign w_sel     = w_fire[1];
    assign w_is_read = {(req_wb[1] == {STRB_WIDTH{1'b0}}), (req_wb[0] == {STRB_WIDTH{1'b0}})};

    // Memory port mux: all-zero when idle.
    always_comb begin
        mem_enable = 1'b0;
        mem_wb     = {STRB_WIDTH{1'b0}};
        mem_addr   = {ADDR_WIDTH{1'b0}};
        mem_wdata  = {DATA_WIDTH{1'b0}};
        if (w_fire != 2'b00) begin
            mem_enable = 1'b1;
            mem_wb     = req_wb[w_sel];
            mem_addr   = req_addr[w_sel];
            mem_wdata  = req_data[w_sel];
        end else begin
            mem_enable = 1'b0;
        end
    end

    // Lock next-state: every transfer re-decides the lock from its own req_lock bit.
    always_comb begin
        w_state_next = r_state;
        if (w_fire[0]) begin
            w_state_next = req_lock[0] ? ST_LOCKED0 : ST_OPEN;
        end else if (w_fire[1]) begin
            w_state_next = req_lock[1] ? ST_LOCKED1 : ST_OPEN;
        end else begin
            w_state_next = r_state;
        end
    end

    // Lock state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_OPEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Response strobe tracks accepted reads; reset drops any read in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 2'b00;
        end else begin
            r_rsp_valid <= w_fire & w_is_read;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Priority pointer hands the next tie to whoever did not just transfer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr <= 1'b0;
        end else if (w_fire != 2'b00) begin
            r_ptr <= ~w_sel;
        end else begin
            r_ptr <= r_ptr;
        end
    end
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = (r_rsp_valid != 2'b00) ? mem_rdata : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory, reference memory and a read-response scoreboard.
module tb_mem_port_arbiter;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_lock;
    logic [1:0][31:0]  req_addr;
    logic [1:0][3:0]   req_wb;
    logic [1:0][31:0]  req_data;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_data;
    logic              mem_enable;
    logic [3:0]        mem_wb;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    typedef struct {
        int          who;
        logic [31:0] data;
        int          at;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem_arr [0:255];
    logic [31:0] ref_arr [0:255];

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
        .req_addr(req_addr), .req_wb(req_wb), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_enable(mem_enable), .mem_wb(mem_wb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        w = 32'hA5000000 | (i & 32'hFF);
        if (i == 4) w = 32'hDEADBEEF;
        if (i == 8) w = 32'h11223344;
        return w;
    endfunction

    // Memory model: registered read data, byte-strobed writes; reloaded while reset is held.
    always @(posedge clock) begin : mem_model
        logic [31:0] w;
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
        end else if (mem_enable) begin
            w = mem_arr[mem_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (mem_wb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_arr[mem_addr[9:2]] <= w;
            mem_rdata <= mem_arr[mem_addr[9:2]];
        end
    end

    // Response monitor: pops scoreboard entries due this cycle, otherwise expects silence.
    always @(negedge clock) begin : rsp_monitor
        exp_t        e;
        logic [1:0]  ev;
        if (sb.size() > 0 && sb[0].at <= cyc) begin
            e  = sb.pop_front();
            ev = (e.who == 1) ? 2'b10 : 2'b01;
            tests_run++;
            if (rsp_valid !== ev || rsp_data !== e.data || e.at != cyc) begin
                tests_failed++;
                $display("FAIL rsp_check: got valid=%b data=%h at cyc %0d, expected valid=%b data=%h at cyc %0d",
                         rsp_valid, rsp_data, cyc, ev, e.data, e.at);
            end
        end else begin
            tests_run++;
            if (rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin
                tests_failed++;
                $display("FAIL rsp_idle: got valid=%b data=%h, expected valid=00 data=00000000", rsp_valid, rsp_data);
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic lk, input logic [31:0] a,
                           input logic [3:0] wb, input logic [31:0] d);
        req_valid[i] = v;
        req_lock[i]  = lk;
        req_addr[i]  = a;
        req_wb[i]    = wb;
        req_data[i]  = d;
    endtask

    task automatic idle();
        req_valid = 2'b00;
        req_lock  = 2'b00;
        req_addr  = '0;
        req_wb    = '0;
        req_data  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic ref_init();
        for (int i = 0; i < 256; i++) ref_arr[i] = init_word(i);
    endtask

    // Bookkeeping at the sample point: reads push an expectation, writes update the reference.
    task automatic record();
        exp_t        e;
        logic [31:0] w;
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                if (req_wb[i] == 4'b0000) begin
                    e.who  = i;
                    e.data = ref_arr[req_addr[i][9:2]];
                    e.at   = cyc + 1;
                    sb.push_back(e);
                end else begin
                    w = ref_arr[req_addr[i][9:2]];
                    for (int b = 0; b < 4; b++)
                        if (req_wb[i][b]) w[8*b +: 8] = req_data[i][8*b +: 8];
                    ref_arr[req_addr[i][9:2]] = w;
                end
            end
        end
    endtask

    task automatic test_reset();
        set_req(0, 1'b1, 1'b1, 32'h10, 4'b1111, 32'h12345678);
        set_req(1, 1'b1, 1'b1, 32'h20, 4'b0000, 32'h9ABCDEF0);
        @(negedge clock);
        tests_run++;
        if (req_ready !== 2'b00 || mem_enable !== 1'b0 || mem_wb !== 4'b0000 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ready=%b en=%b wb=%b addr=%h wdata=%h, expected all zero",
                     req_ready, mem_enable, mem_wb, mem_addr, mem_wdata);
        end
        next_cycle();
        reset = 1'b1;
        idle();
        @(negedge clock);
        tests_run++;
        if (req_ready !== 2'b00 || mem_enable !== 1'b0 || mem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL idle_outputs: got ready=%b en=%b addr=%h, expected 00 0 0", req_ready, mem_enable, mem_addr);
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_g;
        int         nc = 0;
        int         nn = 0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            set_req(0, 1'b1, 1'b0, 32'h40 + 32'(4 * nc), 4'b0000, 32'h0);
            set_req(1, 1'b1, 1'b0, 32'h80 + 32'(4 * nn), 4'b0000, 32'h0);
            @(negedge clock);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            tests_run++;
            if (req_ready !== exp_g || mem_enable !== 1'b1) begin
                tests_failed++;
                $display("FAIL arb_grant[%0d]: got ready=%b en=%b, expected ready=%b en=1", k, req_ready, mem_enable, exp_g);
            end
            record();
            if (req_ready[0]) nc++;
            if (req_ready[1]) nn++;
        end
        next_cycle();
        idle();
        @(negedge clock);
    endtask

    task automatic test_cpu_read();
        next_cycle();
        set_req(0, 1'b1, 1'b0, 32'h10, 4'b0000, 32'h0);
        @(negedge clock);
        tests_run++;
        if (req_ready !== 2'b01 || mem_wb !== 4'b0000 || mem_enable !== 1'b1 || mem_addr !== 32'h10) begin
            tests_failed++;
            $display("FAIL cpu_read_issue: got ready=%b wb=%b en=%b addr=%h, expected 01 0000 1 00000010",
                     req_ready, mem_wb, mem_enable, mem_addr);
        end
        record();
        next_cycle();
        idle();
        @(negedge clock);
        tests_run++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL cpu_read_data: got valid=%b data=%h, expected 01 deadbeef", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_lock_burst();
        logic [31:0] addrs [3];
        logic        locks [3];
        addrs = '{32'h100, 32'h104, 32'h108};
        locks = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            set_req(1, 1'b1, locks[k], addrs[k], 4'b1111, 32'(k + 1));
            if (k > 0) set_req(0, 1'b1, 1'b0, 32'h10, 4'b0000, 32'h0);
            @(negedge clock);
            tests_run++;
            if (req_ready !== 2'b10 || mem_addr !== addrs[k] || mem_wdata !== 32'(k + 1) || mem_wb !== 4'b1111) begin
                tests_failed++;
                $display("FAIL lock_burst[%0d]: got ready=%b addr=%h wdata=%h wb=%b, expected 10 %h %h 1111",
                         k, req_ready, mem_addr, mem_wdata, mem_wb, addrs[k], 32'(k + 1));
            end
            record();
        end
        next_cycle();
        set_req(1, 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        @(negedge clock);
        tests_run++;
        if (req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL lock_release: got ready=%b, expected 01", req_ready);
        end
        record();
        next_cycle();
        idle();
        set_req(1, 1'b1, 1'b0, 32'h104, 4'b0000, 32'h0);
        @(negedge clock);
        record();
        next_cycle();
        idle();
        @(negedge clock);
    endtask

    task automatic test_lock_hold();
        next_cycle();
        set_req(1, 1'b1, 1'b1, 32'h100, 4'b0000, 32'h0);
        @(negedge clock);
        tests_run++;
        if (req_ready !== 2'b10) begin
            tests_failed++;
            $display("FAIL lock_take: got ready=%b, expected 10", req_ready);
        end
        record();
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            set_req(1, 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
            set_req(0, 1'b1, 1'b0, 32'h10, 4'b0000, 32'h0);
            @(negedge clock);
            tests_run++;
            if (req_ready !== 2'b00 || mem_enable !== 1'b0) begin
                tests_failed++;
                $display("FAIL lock_hold[%0d]: got ready=%b en=%b, expected 00 0", k, req_ready, mem_enable);
            end
            record();
        end
        next_cycle();
        set_req(1, 1'b1, 1'b0, 32'h108, 4'b0000, 32'h0);
        @(negedge clock);
        tests_run++;
        if (req_ready !== 2'b10) begin
            tests_failed++;
            $display("FAIL lock_resume: got ready=%b, expected 10", req_ready);
        end
        record();
        next_cycle();
        set_req(1, 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        @(negedge clock);
        tests_run++;
        if (req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL lock_after: got ready=%b, expected 01", req_ready);
        end
        record();
        next_cycle();
        idle();
        @(negedge clock);
    endtask

    task automatic test_byte_write();
        next_cycle();
        set_req(0, 1'b1, 1'b0, 32'h20, 4'b0100, 32'h00AB0000);
        @(negedge clock);
        tests_run++;
        if (req_ready !== 2'b01 || mem_wb !== 4'b0100 || mem_wdata !== 32'h00AB0000) begin
            tests_failed++;
            $display("FAIL byte_write: got ready=%b wb=%b wdata=%h, expected 01 0100 00ab0000", req_ready, mem_wb, mem_wdata);
        end
        record();
        next_cycle();
        set_req(0, 1'b1, 1'b0, 32'h20, 4'b0000, 32'h0);
        @(negedge clock);
        record();
        next_cycle();
        idle();
        @(negedge clock);
        tests_run++;
        if (rsp_data !== 32'h11AB3344) begin
            tests_failed++;
            $display("FAIL byte_readback: got data=%h, expected 11ab3344", rsp_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        addrs = '{32'h10, 32'h20, 32'h104, 32'h44};
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            set_req(0, 1'b1, 1'b0, addrs[k], 4'b0000, 32'h0);
            @(negedge clock);
            tests_run++;
            if (req_ready !== 2'b01 || mem_addr !== addrs[k]) begin
                tests_failed++;
                $display("FAIL b2b[%0d]: got ready=%b addr=%h, expected 01 %h", k, req_ready, mem_addr, addrs[k]);
            end
            record();
        end
        next_cycle();
        idle();
        @(negedge clock);
    endtask

    task automatic test_reset_inflight();
        next_cycle();
        set_req(0, 1'b1, 1'b0, 32'h10, 4'b0000, 32'h0);
        @(negedge clock);
        tests_run++;
        if (req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL inflight_issue: got ready=%b, expected 01", req_ready);
        end
        next_cycle();
        reset = 1'b0;
        set_req(1, 1'b1, 1'b0, 32'h20, 4'b1111, 32'h55);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            tests_run++;
            if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_data !== 32'h0 || mem_enable !== 1'b0 ||
                mem_wb !== 4'b0000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
                tests_failed++;
                $display("FAIL inflight_reset[%0d]: got ready=%b rv=%b rd=%h en=%b wb=%b addr=%h wd=%h, expected all zero",
                         k, req_ready, rsp_valid, rsp_data, mem_enable, mem_wb, mem_addr, mem_wdata);
            end
            next_cycle();
        end
        reset = 1'b1;
        ref_init();
        idle();
        @(negedge clock);
        tests_run++;
        if (rsp_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL inflight_after: got rsp_valid=%b, expected 00", rsp_valid);
        end
        next_cycle();
        set_req(0, 1'b1, 1'b0, 32'h20, 4'b0000, 32'h0);
        @(negedge clock);
        tests_run++;
        if (req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL first_grant: got ready=%b, expected 01", req_ready);
        end
        record();
        next_cycle();
        idle();
        @(negedge clock);
    endtask

    initial begin
        idle();
        ref_init();
        test_reset();
        test_arbitration();
        test_cpu_read();
        test_lock_burst();
        test_lock_hold();
        test_byte_write();
        test_back_to_back();
        test_reset_inflight();
        repeat (3) next_cycle();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: got %0d pending responses, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
